// File: rtl/dram_unpacker_pkg.sv
// Shared constants and FSM encoding for the DRAM readback path.
// Word geometry must match the capture-side packer: four 32-bit lanes per 128-bit word.
package dram_unpacker_pkg;

    localparam int ADX_W         = 27;
    localparam int ADX_STEP      = 8;
    localparam int WORD_W        = 128;
    localparam int PKT_W         = 32;
    localparam int PKTS_PER_WORD = 4;
    localparam int LANE_W        = $clog2(PKTS_PER_WORD);

    localparam logic [ADX_W-1:0]  ADX_INC   = ADX_W'(ADX_STEP);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PKTS_PER_WORD - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/dram_unpacker_serializer.sv
// Holds one returned DRAM word and emits its lanes lane 0 first; a packet is offered the cycle after load.
// pkt_data/pkt_valid hold while pkt_ready is low; the register reopens the cycle after its last lane leaves.
module word_to_packet_serializer
    import dram_unpacker_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic [WORD_W-1:0] word_in,
    input  logic              last_pkt,
    output logic [PKT_W-1:0]  pkt_data,
    output logic              pkt_valid,
    input  logic              pkt_ready,
    output logic              pkt_xfer
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic              full_q, full_d;

    always_comb begin
        word_d   = word_q;
        lane_d   = lane_q;
        full_d   = full_q;
        pkt_xfer = full_q & pkt_ready;
        if (load && !full_q) begin
            word_d = word_in;
            lane_d = '0;
            full_d = 1'b1;
        end else if (pkt_xfer) begin
            // A short final word releases the register early so trailing lanes are dropped.
            if (last_pkt || (lane_q == LAST_LANE)) begin
                full_d = 1'b0;
                lane_d = '0;
            end else begin
                lane_d = lane_q + LANE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            word_q <= '0;
            lane_q <= '0;
            full_q <= 1'b0;
        end else begin
            word_q <= word_d;
            lane_q <= lane_d;
            full_q <= full_d;
        end
    end

    assign pkt_valid = full_q;
    assign pkt_data  = word_q[{lane_q, 5'd0} +: PKT_W];

endmodule

// File: rtl/dram_unpacker.sv
// Reads a run of packed DRAM words and streams their 32-bit packets in capture order; first read_req one cycle after start.
// Up to MAX_OUTSTANDING reads in flight; return pops stall while the holding word is full, packets stall on pkt_ready.
module dram_unpacker
    import dram_unpacker_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADX_W-1:0]  base_adx,
    input  logic [31:0]       packet_count,
    output logic              read_req,
    output logic [ADX_W-1:0]  rd_adx,
    input  logic              read_allowed,
    input  logic              has_return_data,
    output logic              get_return_data,
    input  logic [WORD_W-1:0] rd_data_return,
    input  logic [ADX_W-1:0]  rd_adx_return,
    output logic [PKT_W-1:0]  pkt_data,
    output logic              pkt_valid,
    input  logic              pkt_ready,
    output logic              busy,
    output logic              done,
    output logic              adx_error
);

    localparam logic [3:0] MAX_OS = 4'(MAX_OUTSTANDING);

    state_e            state_q, state_d;
    logic [31:0]       pkt_count_q, pkt_count_d;
    logic [31:0]       words_total_q, words_total_d;
    logic [31:0]       words_issued_q, words_issued_d;
    logic [31:0]       packets_sent_q, packets_sent_d;
    logic [3:0]        outstanding_q, outstanding_d;
    logic [ADX_W-1:0]  next_adx_q, next_adx_d;
    logic [ADX_W-1:0]  expected_adx_q, expected_adx_d;
    logic              read_req_q, read_req_d;
    logic              adx_error_q, adx_error_d;

    logic [32:0]       cnt_plus3;
    logic              req_acc;
    logic              pop;
    logic              pkt_xfer;
    logic              last_pkt;

    assign cnt_plus3 = {1'b0, packet_count} + 33'd3;
    assign req_acc   = read_req_q & read_allowed;
    assign pop       = (state_q == ST_RUN) && !pkt_valid && has_return_data;
    assign last_pkt  = (packets_sent_q + 32'd1) == pkt_count_q;

    always_comb begin
        state_d        = state_q;
        pkt_count_d    = pkt_count_q;
        words_total_d  = words_total_q;
        words_issued_d = words_issued_q;
        packets_sent_d = packets_sent_q;
        outstanding_d  = outstanding_q;
        next_adx_d     = next_adx_q;
        expected_adx_d = expected_adx_q;
        adx_error_d    = adx_error_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    adx_error_d = 1'b0;
                    if (packet_count == 32'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d        = ST_RUN;
                        pkt_count_d    = packet_count;
                        words_total_d  = {1'b0, cnt_plus3[32:2]};
                        words_issued_d = '0;
                        packets_sent_d = '0;
                        outstanding_d  = '0;
                        next_adx_d     = base_adx;
                        expected_adx_d = base_adx;
                    end
                end
            end
            ST_RUN: begin
                if (req_acc) begin
                    next_adx_d     = next_adx_q + ADX_INC;
                    words_issued_d = words_issued_q + 32'd1;
                end
                // A simultaneous accept and pop leaves the credit count unchanged.
                outstanding_d = outstanding_q + {3'b000, req_acc} - {3'b000, pop};
                if (pop) begin
                    expected_adx_d = expected_adx_q + ADX_INC;
                    if (rd_adx_return != expected_adx_q) begin
                        adx_error_d = 1'b1;
                    end
                end
                if (pkt_xfer) begin
                    packets_sent_d = packets_sent_q + 32'd1;
                end
                if (packets_sent_d == pkt_count_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered request: evaluated on next-cycle counts so it only drops once no longer needed.
        read_req_d = (state_d == ST_RUN)
                  && (words_issued_d < words_total_d)
                  && (outstanding_d < MAX_OS);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            pkt_count_q    <= '0;
            words_total_q  <= '0;
            words_issued_q <= '0;
            packets_sent_q <= '0;
            outstanding_q  <= '0;
            next_adx_q     <= '0;
            expected_adx_q <= '0;
            read_req_q     <= 1'b0;
            adx_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            pkt_count_q    <= pkt_count_d;
            words_total_q  <= words_total_d;
            words_issued_q <= words_issued_d;
            packets_sent_q <= packets_sent_d;
            outstanding_q  <= outstanding_d;
            next_adx_q     <= next_adx_d;
            expected_adx_q <= expected_adx_d;
            read_req_q     <= read_req_d;
            adx_error_q    <= adx_error_d;
        end
    end

    word_to_packet_serializer u_ser (
        .clk       (clk),
        .resetn    (resetn),
        .load      (pop),
        .word_in   (rd_data_return),
        .last_pkt  (last_pkt),
        .pkt_data  (pkt_data),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_xfer  (pkt_xfer)
    );

    assign read_req        = read_req_q;
    assign rd_adx          = next_adx_q;
    assign get_return_data = pop;
    assign busy            = (state_q == ST_RUN);
    assign done            = (state_q == ST_DONE);
    assign adx_error       = adx_error_q;

endmodule

// File: tb/tb_dram_unpacker.sv
// Directed and randomized runs of dram_unpacker against a DRAM return model and a packet-order reference.
module tb_dram_unpacker;
    import dram_unpacker_pkg::*;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic [ADX_W-1:0]  base_adx = '0;
    logic [31:0]       packet_count = '0;
    logic              read_req;
    logic [ADX_W-1:0]  rd_adx;
    logic              read_allowed = 1'b0;
    logic              has_return_data = 1'b0;
    logic              get_return_data;
    logic [WORD_W-1:0] rd_data_return = '0;
    logic [ADX_W-1:0]  rd_adx_return = '0;
    logic [PKT_W-1:0]  pkt_data;
    logic              pkt_valid;
    logic              pkt_ready = 1'b0;
    logic              busy;
    logic              done;
    logic              adx_error;

    dram_unpacker #(.MAX_OUTSTANDING(4)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .start           (start),
        .base_adx        (base_adx),
        .packet_count    (packet_count),
        .read_req        (read_req),
        .rd_adx          (rd_adx),
        .read_allowed    (read_allowed),
        .has_return_data (has_return_data),
        .get_return_data (get_return_data),
        .rd_data_return  (rd_data_return),
        .rd_adx_return   (rd_adx_return),
        .pkt_data        (pkt_data),
        .pkt_valid       (pkt_valid),
        .pkt_ready       (pkt_ready),
        .busy            (busy),
        .done            (done),
        .adx_error       (adx_error)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] FIXED_WORD = 128'h0000_4444_0000_3333_0000_2222_0000_1111;

    int n_vec = 0;
    int n_bad = 0;

    int cyc = 0;
    int lat = 10, rmode = 0, amode = 0, blk_lo = -1, blk_hi = -1;
    bit corrupt = 1'b0, fixed_mode = 1'b0;
    logic [31:0] seed = 32'h1234_5678;

    logic [ADX_W-1:0] acc_adx[$];
    logic [ADX_W-1:0] pend_adx[$];
    int               pend_t[$];
    logic [ADX_W-1:0] ret_q[$];
    logic [31:0]      got[$];
    int n_done = 0, os = 0, max_os = 0, n_pop = 0;
    int stall_err = 0, req_err = 0, get_err = 0, rq_blocked = 0;
    int start_cyc = 0, done_cyc = 0;
    bit stall_prev = 1'b0, rq_prev = 1'b0;
    logic [31:0]      stall_dat = '0;
    logic [ADX_W-1:0] rq_adx = '0;

    function automatic logic [127:0] mem_word(input logic [ADX_W-1:0] adx);
        logic [31:0] a;
        a = 32'(adx);
        if (fixed_mode) return FIXED_WORD;
        return {(a * 32'h9E37_79B1) ^ seed, a ^ ~seed, seed + a, (a * 32'd7) + seed};
    endfunction

    // Memory, controller and consumer model: drive on the falling edge, observe 1 time unit later.
    always begin
        @(negedge clk);
        cyc = cyc + 1;
        if (!resetn) begin
            has_return_data = 1'b0;
        end else begin
            while (pend_t.size() > 0 && pend_t[0] <= cyc) begin
                ret_q.push_back(pend_adx.pop_front());
                void'(pend_t.pop_front());
            end
            has_return_data = (ret_q.size() > 0);
            if (ret_q.size() > 0) begin
                rd_data_return = mem_word(ret_q[0]);
                rd_adx_return  = (corrupt && n_pop == 0) ? (ret_q[0] ^ ADX_W'(8)) : ret_q[0];
            end
            case (rmode)
                1:       pkt_ready = (cyc % 3 == 0);
                2:       pkt_ready = $urandom_range(0, 1) == 1;
                default: pkt_ready = 1'b1;
            endcase
            if (cyc >= blk_lo && cyc < blk_hi)  read_allowed = 1'b0;
            else if (amode == 1)                read_allowed = $urandom_range(0, 1) == 1;
            else                                read_allowed = 1'b1;
        end
        #1;
        if (!resetn) begin
            ret_q.delete(); pend_adx.delete(); pend_t.delete();
            os = 0; stall_prev = 1'b0; rq_prev = 1'b0;
        end else begin
            if (get_return_data) begin
                if (!has_return_data) get_err++;
                else begin void'(ret_q.pop_front()); os--; n_pop++; end
            end
            if (read_req && read_allowed) begin
                acc_adx.push_back(rd_adx);
                pend_adx.push_back(rd_adx);
                pend_t.push_back(cyc + lat);
                os++;
            end
            if (os > max_os) max_os = os;
            if (read_req && !read_allowed) rq_blocked++;
            if (stall_prev && !(pkt_valid && pkt_data == stall_dat)) stall_err++;
            stall_prev = pkt_valid && !pkt_ready;
            stall_dat  = pkt_data;
            if (rq_prev && !(read_req && rd_adx == rq_adx)) req_err++;
            rq_prev = read_req && !read_allowed;
            rq_adx  = rd_adx;
            if (pkt_valid && pkt_ready) got.push_back(pkt_data);
            if (done) begin n_done++; done_cyc = cyc; end
            if (start) start_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [ADX_W-1:0] b, input int cnt, input int l,
                             input int rm, input int am, input bit corr, input int blk);
        lat = l; rmode = rm; amode = am; corrupt = corr; seed = $urandom;
        got.delete(); acc_adx.delete();
        n_done = 0; max_os = 0; n_pop = 0; stall_err = 0; req_err = 0; get_err = 0; rq_blocked = 0;
        start_cyc = 0; done_cyc = 0;
        blk_lo = (blk > 0) ? cyc + blk : -1;
        blk_hi = (blk > 0) ? blk_lo + 15 : -1;
        @(posedge clk); #1;
        base_adx = b; packet_count = cnt; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 5000 && n_done == 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_run(input string tag, input logic [ADX_W-1:0] b, input int cnt, input bit exp_err);
        int nw, bad_idx, bad_adx;
        logic [127:0] w;
        logic [31:0]  p;
        nw = (cnt + 3) / 4;
        bad_idx = -1;
        for (int j = 0; j < cnt; j++) begin
            w = mem_word(b + ADX_W'((j / 4) * ADX_STEP));
            p = 32'(w >> (32 * (j % 4)));
            if (bad_idx < 0 && (j >= got.size() || got[j] !== p)) bad_idx = j;
        end
        bad_adx = -1;
        for (int i = 0; i < acc_adx.size(); i++)
            if (bad_adx < 0 && acc_adx[i] !== b + ADX_W'(i * ADX_STEP)) bad_adx = i;
        chk({tag, " done_pulses"}, n_done, 1);
        chk({tag, " pkt_count"}, got.size(), cnt);
        chk({tag, " first_bad_pkt"}, bad_idx, -1);
        chk({tag, " read_count"}, acc_adx.size(), nw);
        chk({tag, " first_bad_adx"}, bad_adx, -1);
        chk({tag, " stall_stable"}, stall_err, 0);
        chk({tag, " req_stable"}, req_err, 0);
        chk({tag, " get_legal"}, get_err, 0);
        chk({tag, " credit_bound"}, max_os <= 4, 1);
        chk({tag, " adx_error"}, adx_error, exp_err);
        chk({tag, " idle_busy"}, busy, 0);
    endtask

    initial begin
        logic [31:0] g;
        logic [ADX_W-1:0] rb;
        int rc;

        repeat (3) @(posedge clk); #1;
        chk("reset read_req", read_req, 0);
        chk("reset rd_adx", rd_adx, 0);
        chk("reset get", get_return_data, 0);
        chk("reset pkt_valid", pkt_valid, 0);
        chk("reset pkt_data", pkt_data, 0);
        chk("reset busy_done_err", {busy, done, adx_error}, 0);
        resetn = 1'b1;

        fixed_mode = 1'b1;
        start_run('0, 4, 10, 0, 0, 1'b0, 0);
        wait_done();
        check_run("basic", '0, 4, 1'b0);
        for (int k = 0; k < 4; k++) begin
            g = (k < got.size()) ? got[k] : 32'hDEAD_BEEF;
            chk($sformatf("basic lane%0d", k), g, 32'h1111 * (k + 1));
        end
        fixed_mode = 1'b0;

        start_run('0, 8, 6, 0, 0, 1'b1, 0);
        wait_done();
        check_run("mismatch", '0, 8, 1'b1);

        start_run(ADX_W'(32'h100), 6, 5, 0, 0, 1'b0, 0);
        wait_done();
        check_run("partial", ADX_W'(32'h100), 6, 1'b0);
        chk("partial second_adx", (acc_adx.size() > 1) ? 64'(acc_adx[1]) : 64'hFFFF, 64'h108);

        start_run(ADX_W'(32'h2000), 100, 20, 1, 0, 1'b0, 0);
        repeat (30) @(posedge clk); #1;
        chk("restart busy", busy, 1);
        base_adx = ADX_W'(32'h555); packet_count = 3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        check_run("backpressure", ADX_W'(32'h2000), 100, 1'b0);
        chk("backpressure credit_peak", max_os, 4);

        start_run(ADX_W'(32'h40), 40, 3, 0, 0, 1'b0, 8);
        wait_done();
        check_run("flowctl", ADX_W'(32'h40), 40, 1'b0);
        chk("flowctl blocked_seen", rq_blocked > 0, 1);

        start_run(ADX_W'(32'h80), 0, 5, 0, 0, 1'b0, 0);
        wait_done();
        chk("zero done_pulses", n_done, 1);
        chk("zero no_reads", acc_adx.size(), 0);
        chk("zero done_latency", (done_cyc - start_cyc >= 1) && (done_cyc - start_cyc <= 2), 1);

        for (int r = 0; r < 3; r++) begin
            rb = (r == 0) ? ADX_W'(32'h7FF_FFF0) : ADX_W'($urandom);
            rc = $urandom_range(1, 40);
            start_run(rb, rc, $urandom_range(1, 25), 2, 1, 1'b0, 0);
            wait_done();
            check_run($sformatf("random%0d", r), rb, rc, 1'b0);
        end

        start_run('0, 60, 20, 0, 0, 1'b1, 0);
        repeat (40) @(posedge clk); #1;
        chk("midrun adx_error", adx_error, 1);
        chk("midrun busy", busy, 1);
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("midrun_rst read_req", read_req, 0);
        chk("midrun_rst rd_adx", rd_adx, 0);
        chk("midrun_rst get", get_return_data, 0);
        chk("midrun_rst pkt", {pkt_valid, pkt_data}, 0);
        chk("midrun_rst busy_done_err", {busy, done, adx_error}, 0);
        repeat (2) @(posedge clk); #1;
        resetn = 1'b1;

        start_run(ADX_W'(32'h300), 9, 4, 2, 1, 1'b0, 0);
        wait_done();
        check_run("recover", ADX_W'(32'h300), 9, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
